// File: rtl/decodificador_hamming.sv
// Hamming (8,4) SECDED decoder: two-stage valid/ready pipeline with
// single-error correction, double-error detection and saturating error counters.
module decodificador_hamming #(
    parameter int ANCHO_CUENTA = 8
) (
    input  logic                    reloj,
    input  logic                    reset,
    input  logic [7:0]              palabra,
    input  logic                    entrada_valida,
    output logic                    entrada_lista,
    output logic [3:0]              dato_salida,
    output logic                    error_simple,
    output logic                    error_doble,
    output logic [2:0]              posicion_error,
    output logic                    salida_valida,
    input  logic                    salida_lista,
    input  logic                    limpiar_contadores,
    output logic [ANCHO_CUENTA-1:0] cuenta_corregidos,
    output logic [ANCHO_CUENTA-1:0] cuenta_dobles
);

    localparam logic [ANCHO_CUENTA-1:0] MAXIMO = '1;

    logic       v1;
    logic [7:0] w1;
    logic       ready2;
    logic       carga1;
    logic       salida_tx;

    logic [2:0] s;
    logic       g;
    logic [7:0] wc;
    logic [3:0] dato_c;
    logic       simple_c;
    logic       doble_c;

    assign ready2        = !salida_valida || salida_lista;
    assign entrada_lista = !v1 || ready2;
    assign carga1        = entrada_valida && entrada_lista;
    assign salida_tx     = salida_valida && salida_lista;

    // Syndrome and overall parity of the word held in stage 1
    always_comb begin
        s[0]     = w1[1] ^ w1[3] ^ w1[5] ^ w1[7];
        s[1]     = w1[2] ^ w1[3] ^ w1[6] ^ w1[7];
        s[2]     = w1[4] ^ w1[5] ^ w1[6] ^ w1[7];
        g        = ^w1;
        wc       = w1;
        simple_c = 1'b0;
        doble_c  = 1'b0;
        unique case (1'b1)
            (s == 3'd0) && !g: ;
            (s != 3'd0) && g: begin
                wc[s]    = ~w1[s];
                simple_c = 1'b1;
            end
            (s == 3'd0) && g: simple_c = 1'b1;
            (s != 3'd0) && !g: doble_c = 1'b1;
        endcase
        dato_c = {wc[7], wc[6], wc[5], wc[3]};
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0;
            w1 <= 8'd0;
        end else if (carga1) begin
            v1 <= 1'b1;
            w1 <= palabra;
        end else if (v1 && ready2) begin
            v1 <= 1'b0;
        end
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            salida_valida  <= 1'b0;
            dato_salida    <= 4'd0;
            error_simple   <= 1'b0;
            error_doble    <= 1'b0;
            posicion_error <= 3'd0;
        end else if (ready2) begin
            salida_valida <= v1;
            if (v1) begin
                dato_salida    <= dato_c;
                error_simple   <= simple_c;
                error_doble    <= doble_c;
                posicion_error <= s;
            end
        end
    end

    // Clear wins over a coinciding increment
    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            cuenta_corregidos <= '0;
            cuenta_dobles     <= '0;
        end else if (limpiar_contadores) begin
            cuenta_corregidos <= '0;
            cuenta_dobles     <= '0;
        end else if (salida_tx) begin
            if (error_simple && cuenta_corregidos != MAXIMO)
                cuenta_corregidos <= cuenta_corregidos + ANCHO_CUENTA'(1);
            if (error_doble && cuenta_dobles != MAXIMO)
                cuenta_dobles <= cuenta_dobles + ANCHO_CUENTA'(1);
        end
    end

endmodule

// File: tb/tb_decodificador_hamming.sv
// Directed bench for decodificador_hamming: decode cases, backpressure,
// counter saturation (second instance, ANCHO_CUENTA=2), clear and reset.
module tb_decodificador_hamming;

    logic       reloj = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] palabra = 8'd0;
    logic       entrada_valida = 1'b0;
    logic       salida_lista = 1'b1;
    logic       limpiar = 1'b0;

    logic       entrada_lista;
    logic [3:0] dato_salida;
    logic       error_simple;
    logic       error_doble;
    logic [2:0] posicion_error;
    logic       salida_valida;
    logic [7:0] cuenta_corregidos;
    logic [7:0] cuenta_dobles;

    logic       s_entrada_lista;
    logic [3:0] s_dato;
    logic       s_simple;
    logic       s_doble;
    logic [2:0] s_pos;
    logic       s_valida;
    logic [1:0] s_corr;
    logic [1:0] s_dob;

    int checks = 0;
    int errors = 0;
    int n_corr = 0;
    int n_dob = 0;

    always #5 reloj = ~reloj;

    decodificador_hamming u_dut (
        .reloj(reloj), .reset(reset), .palabra(palabra),
        .entrada_valida(entrada_valida), .entrada_lista(entrada_lista),
        .dato_salida(dato_salida), .error_simple(error_simple),
        .error_doble(error_doble), .posicion_error(posicion_error),
        .salida_valida(salida_valida), .salida_lista(salida_lista),
        .limpiar_contadores(limpiar),
        .cuenta_corregidos(cuenta_corregidos), .cuenta_dobles(cuenta_dobles)
    );

    decodificador_hamming #(.ANCHO_CUENTA(2)) u_sat (
        .reloj(reloj), .reset(reset), .palabra(palabra),
        .entrada_valida(entrada_valida), .entrada_lista(s_entrada_lista),
        .dato_salida(s_dato), .error_simple(s_simple),
        .error_doble(s_doble), .posicion_error(s_pos),
        .salida_valida(s_valida), .salida_lista(salida_lista),
        .limpiar_contadores(limpiar),
        .cuenta_corregidos(s_corr), .cuenta_dobles(s_dob)
    );

    task automatic comprobar(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic comprobar_salida(input string tag, input logic [3:0] d,
                                    input logic es, input logic ed,
                                    input logic [2:0] p);
        comprobar({tag, " valida"}, 32'(salida_valida), 32'd1);
        comprobar({tag, " dato"}, 32'(dato_salida), 32'(d));
        comprobar({tag, " simple"}, 32'(error_simple), 32'(es));
        comprobar({tag, " doble"}, 32'(error_doble), 32'(ed));
        comprobar({tag, " pos"}, 32'(posicion_error), 32'(p));
    endtask

    task automatic comprobar_cuentas(input string tag);
        comprobar({tag, " corr"}, 32'(cuenta_corregidos), 32'(n_corr));
        comprobar({tag, " dob"}, 32'(cuenta_dobles), 32'(n_dob));
        comprobar({tag, " corr sat"}, 32'(s_corr), 32'(n_corr > 3 ? 3 : n_corr));
        comprobar({tag, " dob sat"}, 32'(s_dob), 32'(n_dob > 3 ? 3 : n_dob));
    endtask

    task automatic transaccion(input string tag, input logic [7:0] w,
                               input logic [3:0] d, input logic es,
                               input logic ed, input logic [2:0] p);
        int lat;
        @(negedge reloj);
        palabra = w;
        entrada_valida = 1'b1;
        @(posedge reloj);
        @(negedge reloj);
        entrada_valida = 1'b0;
        lat = 1;
        while (!salida_valida && lat < 8) begin
            @(posedge reloj);
            @(negedge reloj);
            lat++;
        end
        comprobar({tag, " latencia"}, 32'(lat), 32'd2);
        comprobar_salida(tag, d, es, ed, p);
        @(negedge reloj);
        if (es) n_corr++;
        if (ed) n_dob++;
        comprobar_cuentas(tag);
    endtask

    initial begin
        int vistos;
        repeat (3) @(negedge reloj);
        reset = 1'b0;
        #1;
        comprobar("rst valida", 32'(salida_valida), 32'd0);
        comprobar("rst dato", 32'(dato_salida), 32'd0);
        comprobar("rst flags", 32'({error_simple, error_doble}), 32'd0);
        comprobar("rst pos", 32'(posicion_error), 32'd0);
        comprobar("rst lista", 32'(entrada_lista), 32'd1);
        comprobar_cuentas("rst");

        transaccion("limpia", 8'hAA, 4'b1011, 1'b0, 1'b0, 3'd0);
        transaccion("simple", 8'h8A, 4'b1011, 1'b1, 1'b0, 3'd5);
        transaccion("p0", 8'hAB, 4'b1011, 1'b1, 1'b0, 3'd0);
        transaccion("doble", 8'h82, 4'b1000, 1'b0, 1'b1, 3'd6);

        // Backpressure: two words held, third waits
        salida_lista = 1'b0;
        palabra = 8'hAA;
        entrada_valida = 1'b1;
        @(posedge reloj);
        @(negedge reloj);
        palabra = 8'h8A;
        @(posedge reloj);
        @(negedge reloj);
        palabra = 8'h82;
        comprobar("bp lista", 32'(entrada_lista), 32'd0);
        comprobar_salida("bp aa", 4'b1011, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge reloj);
            @(negedge reloj);
            comprobar("bp lista hold", 32'(entrada_lista), 32'd0);
            comprobar("bp dato hold", 32'(dato_salida), 32'(4'b1011));
        end
        salida_lista = 1'b1;
        @(posedge reloj);
        @(negedge reloj);
        entrada_valida = 1'b0;
        comprobar_salida("bp 8a", 4'b1011, 1'b1, 1'b0, 3'd5);
        @(posedge reloj);
        @(negedge reloj);
        n_corr++;
        comprobar_salida("bp 82", 4'b1000, 1'b0, 1'b1, 3'd6);
        @(posedge reloj);
        @(negedge reloj);
        n_dob++;
        comprobar("bp vacio", 32'(salida_valida), 32'd0);
        comprobar_cuentas("bp");

        for (int i = 0; i < 5; i++)
            transaccion("sat", 8'h8A, 4'b1011, 1'b1, 1'b0, 3'd5);
        comprobar("sat corr 3", 32'(s_corr), 32'd3);

        // Clear coincides with an error_simple output transfer
        @(negedge reloj);
        palabra = 8'h8A;
        entrada_valida = 1'b1;
        @(posedge reloj);
        @(negedge reloj);
        entrada_valida = 1'b0;
        @(posedge reloj);
        @(negedge reloj);
        comprobar_salida("clr", 4'b1011, 1'b1, 1'b0, 3'd5);
        limpiar = 1'b1;
        @(posedge reloj);
        @(negedge reloj);
        limpiar = 1'b0;
        n_corr = 0;
        n_dob = 0;
        comprobar_cuentas("clr");

        transaccion("doble2", 8'h82, 4'b1000, 1'b0, 1'b1, 3'd6);

        // Reset with two words in flight
        salida_lista = 1'b0;
        @(negedge reloj);
        palabra = 8'hAA;
        entrada_valida = 1'b1;
        @(posedge reloj);
        @(negedge reloj);
        palabra = 8'h8A;
        @(posedge reloj);
        @(negedge reloj);
        entrada_valida = 1'b0;
        comprobar("mid valida", 32'(salida_valida), 32'd1);
        #2 reset = 1'b1;
        #1;
        n_corr = 0;
        n_dob = 0;
        comprobar("mid rst valida", 32'(salida_valida), 32'd0);
        comprobar("mid rst dato", 32'(dato_salida), 32'd0);
        comprobar("mid rst lista", 32'(entrada_lista), 32'd1);
        comprobar_cuentas("mid rst");
        @(negedge reloj);
        reset = 1'b0;
        salida_lista = 1'b1;
        vistos = 0;
        repeat (6) begin
            @(posedge reloj);
            @(negedge reloj);
            if (salida_valida) vistos++;
        end
        comprobar("post rst salidas", 32'(vistos), 32'd0);
        comprobar_cuentas("post rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
